result_unloader: RTL and testbench

//  Output side of the matrix multiplier: the reader for the 3x3 MAC grid.

---
 rtl/result_unloader_pkg.sv | 24 ++
 rtl/result_snapshot.sv | 39 +++
 rtl/result_unloader.sv | 135 +++++++++++++
 tb/tb_result_unloader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/result_unloader_pkg.sv
// Shared constants, FSM encoding and index helper for the MAC-grid result unloader.
package result_unloader_pkg;

    localparam int MAC_N         = 9;
    localparam int GRID          = 3;
    localparam int RES_W_DEF     = 10;
    localparam int DRAIN_CYC_DEF = 4;
    localparam int ADDR_W        = 4;
    localparam int DIM_W         = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Flat MAC number for grid position (row i, col j); the grid is always 3 wide.
    function automatic logic [ADDR_W-1:0] mac_index(input logic [DIM_W-1:0] i,
                                                    input logic [DIM_W-1:0] j);
        return ({2'b00, i} * ADDR_W'(GRID)) + {2'b00, j};
    endfunction

endpackage

// File: rtl/result_snapshot.sv
// Snapshot bank of the nine MAC results, loaded once per transfer and read by grid index.
module result_snapshot
    import result_unloader_pkg::*;
#(
    parameter int RES_W = RES_W_DEF
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   load,
    input  logic [MAC_N*RES_W-1:0] mac_res,
    input  logic [ADDR_W-1:0]      rd_idx,
    output logic [RES_W-1:0]       rd_data
);

    logic [RES_W-1:0] bank_q [MAC_N];

    // NOTE: this bank is cleared on reset on purpose: after a clear the unloader must
    // never present stale results, so it is not left as an unreset storage array.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int m = 0; m < MAC_N; m++) begin
                bank_q[m] <= '0;
            end
        end else if (load) begin
            for (int m = 0; m < MAC_N; m++) begin
                bank_q[m] <= mac_res[m*RES_W +: RES_W];
            end
        end
    end

    // NOTE: the read mux gets a default before the guarded select so no latch is inferred.
    always_comb begin
        rd_data = '0;
        if (rd_idx < ADDR_W'(MAC_N)) begin
            rd_data = bank_q[rd_idx];
        end
    end

endmodule

// File: rtl/result_unloader.sv
// Waits for unload_res to rise, lets the systolic grid drain, snapshots the MACs and
// streams the row_w x col_x result matrix row-major on a valid/ready port.
module result_unloader
    import result_unloader_pkg::*;
#(
    parameter int RES_W     = RES_W_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   clear_res,
    input  logic                   unload_res,
    input  logic [MAC_N*RES_W-1:0] mac_res,
    input  logic [DIM_W-1:0]       row_w,
    input  logic [DIM_W-1:0]       col_x,
    input  logic                   out_ready,
    output logic [RES_W-1:0]       data_out,
    output logic                   data_valid,
    output logic [ADDR_W-1:0]      addr_out,
    output logic                   busy,
    output logic                   done
);

    localparam int              CNT_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYC - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIM_W-1:0]   i_q, i_d;
    logic [DIM_W-1:0]   j_q, j_d;
    logic [ADDR_W-1:0]  k_q, k_d;
    logic [DIM_W-1:0]   rows_q, rows_d;
    logic [DIM_W-1:0]   cols_q, cols_d;
    logic               unload_q;
    logic               start;
    logic               snap_load;
    logic [RES_W-1:0]   snap_data;

    assign start = unload_res & ~unload_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        snap_load = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    // Dimensions are captured together with the data so later changes are ignored.
                    snap_load = 1'b1;
                    rows_d    = row_w;
                    cols_d    = col_x;
                    i_d       = '0;
                    j_d       = '0;
                    k_d       = '0;
                    state_d   = (row_w == '0 || col_x == '0) ? ST_DONE : ST_SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    k_d = k_q + ADDR_W'(1);
                    if (j_q == cols_q - DIM_W'(1)) begin
                        j_d = '0;
                        if (i_q == rows_q - DIM_W'(1)) begin
                            state_d = ST_DONE;
                        end else begin
                            i_d = i_q + DIM_W'(1);
                        end
                    end else begin
                        j_d = j_q + DIM_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear_res) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            unload_q <= unload_res;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            unload_q <= unload_res;
        end
    end

    result_snapshot #(
        .RES_W (RES_W)
    ) u_snapshot (
        .clk     (clk),
        .clear   (clear_res),
        .load    (snap_load),
        .mac_res (mac_res),
        .rd_idx  (mac_index(i_q, j_q)),
        .rd_data (snap_data)
    );

    assign data_valid = (state_q == ST_SEND);
    assign data_out   = data_valid ? snap_data : '0;
    assign addr_out   = data_valid ? k_q : '0;
    assign busy       = (state_q == ST_DRAIN) || (state_q == ST_SEND);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_result_unloader.sv
// Self-checking bench for result_unloader: table-driven transfers with a scoreboard,
// plus hand-written clear/re-arm sequences.
module tb_result_unloader;
    import result_unloader_pkg::*;

    localparam int RES_W = 10;
    localparam int DRAIN = 4;

    logic                   clk = 1'b0;
    logic                   clear_res;
    logic                   unload_res;
    logic [MAC_N*RES_W-1:0] mac_res;
    logic [1:0]             row_w;
    logic [1:0]             col_x;
    logic                   out_ready;
    logic [RES_W-1:0]       data_out;
    logic                   data_valid;
    logic [3:0]             addr_out;
    logic                   busy;
    logic                   done;

    always #5 clk = ~clk;

    result_unloader #(
        .RES_W     (RES_W),
        .DRAIN_CYC (DRAIN)
    ) dut (
        .clk        (clk),
        .clear_res  (clear_res),
        .unload_res (unload_res),
        .mac_res    (mac_res),
        .row_w      (row_w),
        .col_x      (col_x),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .addr_out   (addr_out),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [RES_W-1:0] data;
        logic [3:0]       addr;
    } beat_t;

    typedef struct {
        logic [1:0] row;
        logic [1:0] col;
        int         ready_mode;  // 0 always, 1 pattern 1,0,0, 2 random
        int         mac_mode;    // 0 m+1, 1 m+1 with MAC8=3FF, 2 random
        bit         clobber;     // zero mac_res and dims one cycle after snapshot
        int         exp_beats;
    } vec_t;

    int               n_tests = 0;
    int               n_fail  = 0;
    beat_t            sb_q[$];
    logic [RES_W-1:0] mac_v [MAC_N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mac(input int mode);
        for (int m = 0; m < MAC_N; m++) begin
            case (mode)
                1:       mac_v[m] = (m == 8) ? 10'h3FF : RES_W'(m + 1);
                2:       mac_v[m] = RES_W'($urandom_range(0, 1023));
                default: mac_v[m] = RES_W'(m + 1);
            endcase
            mac_res[m*RES_W +: RES_W] = mac_v[m];
        end
    endtask

    // Starts a transfer (caller is #1 after a posedge with unload_res low) and checks it.
    task automatic run_transfer(input vec_t v);
        int    cyc;
        int    first_valid;
        int    done_cyc;
        int    last_acc;
        int    beats;
        bit    stalled;
        beat_t held;
        beat_t exp_b;

        load_mac(v.mac_mode);
        row_w = v.row;
        col_x = v.col;
        for (int i = 0; i < int'(v.row); i++) begin
            for (int j = 0; j < int'(v.col); j++) begin
                sb_q.push_back('{data: mac_v[3*i + j], addr: 4'(i * int'(v.col) + j)});
            end
        end
        unload_res  = 1'b1;
        cyc         = 0;
        first_valid = -1;
        done_cyc    = -1;
        last_acc    = -1;
        beats       = 0;
        stalled     = 1'b0;
        held        = '{data: '0, addr: '0};

        while (done_cyc < 0 && cyc < 300) begin
            tick();
            cyc++;
            if (v.clobber && cyc == DRAIN + 1) begin
                mac_res = '0;
                row_w   = 2'd0;
                col_x   = 2'd0;
            end
            case (v.ready_mode)
                1:       out_ready = ((cyc - (DRAIN + 1)) % 3 == 0);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            if (cyc == 1) check("busy in drain", 32'(busy), 32'd1);
            if (data_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (stalled) begin
                    check("held data", 32'(data_out), 32'(held.data));
                    check("held addr", 32'(addr_out), 32'(held.addr));
                end
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected beat", 32'd1, 32'd0);
                    end else begin
                        exp_b = sb_q.pop_front();
                        check("beat data", 32'(data_out), 32'(exp_b.data));
                        check("beat addr", 32'(addr_out), 32'(exp_b.addr));
                    end
                    beats++;
                    last_acc = cyc + 1;
                    stalled  = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = '{data: data_out, addr: addr_out};
                end
            end
            if (done) begin
                done_cyc = cyc;
                check("busy low in done", 32'(busy), 32'd0);
            end
        end

        check("done seen", 32'(done_cyc >= 0), 32'd1);
        if (v.exp_beats > 0) begin
            check("first beat latency", 32'(first_valid), 32'(DRAIN + 1));
            check("done after last beat", 32'(done_cyc), 32'(last_acc));
        end else begin
            check("no valid when empty", 32'(first_valid < 0), 32'd1);
            check("empty done latency", 32'(done_cyc), 32'(DRAIN + 1));
        end
        check("beat count", 32'(beats), 32'(v.exp_beats));
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        out_ready = 1'b1;
        tick();
        check("done one cycle", 32'(done), 32'd0);
        check("busy after done", 32'(busy), 32'd0);
        check("valid after done", 32'(data_valid), 32'd0);
    endtask

    // Holds inputs for n cycles and checks that no transfer starts.
    task automatic expect_idle(input string name, input int n);
        int busy_seen;
        busy_seen = 0;
        for (int c = 0; c < n; c++) begin
            tick();
            if (busy || data_valid || done) busy_seen++;
        end
        check(name, 32'(busy_seen), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int cyc;

        vecs[0] = '{row: 2'd2, col: 2'd2, ready_mode: 0, mac_mode: 0, clobber: 1'b0, exp_beats: 4};
        vecs[1] = '{row: 2'd3, col: 2'd3, ready_mode: 1, mac_mode: 0, clobber: 1'b0, exp_beats: 9};
        vecs[2] = '{row: 2'd3, col: 2'd3, ready_mode: 0, mac_mode: 1, clobber: 1'b1, exp_beats: 9};
        vecs[3] = '{row: 2'd0, col: 2'd2, ready_mode: 0, mac_mode: 0, clobber: 1'b0, exp_beats: 0};
        vecs[4] = '{row: 2'd3, col: 2'd1, ready_mode: 2, mac_mode: 2, clobber: 1'b0, exp_beats: 3};

        // Reset with unload_res already high: the level alone must not start a transfer.
        clear_res  = 1'b1;
        unload_res = 1'b1;
        mac_res    = '0;
        row_w      = 2'd0;
        col_x      = 2'd0;
        out_ready  = 1'b1;
        tick();
        tick();
        check("reset data_out", 32'(data_out), 32'd0);
        check("reset valid", 32'(data_valid), 32'd0);
        check("reset addr", 32'(addr_out), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        clear_res = 1'b0;
        expect_idle("level high no start", 8);
        unload_res = 1'b0;
        tick();

        foreach (vecs[n]) begin
            run_transfer(vecs[n]);
            unload_res = 1'b0;
            tick();
            tick();
        end

        // Clear on the third SEND beat with unload_res held high.
        load_mac(0);
        row_w      = 2'd3;
        col_x      = 2'd3;
        out_ready  = 1'b1;
        unload_res = 1'b1;
        cyc        = 0;
        while (!(data_valid && addr_out == 4'd2) && cyc < 50) begin
            tick();
            cyc++;
        end
        check("reached third beat", 32'(cyc < 50), 32'd1);
        check("third beat data", 32'(data_out), 32'd3);
        clear_res = 1'b1;
        tick();
        check("clear data_out", 32'(data_out), 32'd0);
        check("clear valid", 32'(data_valid), 32'd0);
        check("clear addr", 32'(addr_out), 32'd0);
        check("clear busy", 32'(busy), 32'd0);
        check("clear done", 32'(done), 32'd0);
        clear_res = 1'b0;
        expect_idle("no restart after clear", 10);
        unload_res = 1'b0;
        tick();

        // Held-high unload after done must not retrigger; a fresh edge must.
        run_transfer('{row: 2'd2, col: 2'd3, ready_mode: 0, mac_mode: 2, clobber: 1'b0, exp_beats: 6});
        expect_idle("no retrigger while high", 15);
        unload_res = 1'b0;
        tick();
        run_transfer('{row: 2'd1, col: 2'd3, ready_mode: 0, mac_mode: 0, clobber: 1'b0, exp_beats: 3});
        unload_res = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
